// File: rtl/polar_to_complex.sv
// polar_to_complex: pipelined rotation-mode CORDIC turning (mag, phase) into a gain-compensated signed I/Q sample
module polar_to_complex #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ITER   = 14
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic        [DATA_WIDTH-1:0] mag,
    input  logic        [15:0]           phase,
    input  logic                         input_strobe,
    output logic signed [DATA_WIDTH-1:0] i,
    output logic signed [DATA_WIDTH-1:0] q,
    output logic                         output_strobe
);
    localparam int W = DATA_WIDTH + 4;
    localparam logic signed [W-1:0] SAT_MAX = {5'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = -SAT_MAX;
    localparam logic signed [W-1:0] HALF = {{(W-2){1'b0}}, 2'b10};
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41, 16'd20, 16'd10, 16'd5, 16'd3, 16'd1, 16'd1, 16'd1
    };

    function automatic logic signed [DATA_WIDTH-1:0] out_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        r = (v + HALF) >>> 2;
        return r > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] :
               r < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
    endfunction

    logic        [W-1:0]          m, mk;
    logic                         fold;
    logic signed [W-1:0]          x_q [NUM_ITER+1];
    logic signed [W-1:0]          x_d [NUM_ITER+1];
    logic signed [W-1:0]          y_q [NUM_ITER+1];
    logic signed [W-1:0]          y_d [NUM_ITER+1];
    logic        [15:0]           z_q [NUM_ITER];
    logic        [15:0]           z_d [NUM_ITER];
    logic        [NUM_ITER+1:0]   stb_q, stb_d;
    logic signed [DATA_WIDTH-1:0] i_q, i_d, q_q, q_d;

    assign m    = {2'b00, mag, 2'b00};
    assign mk   = (m >> 1) + (m >> 3) - (m >> 6) - (m >> 9) - (m >> 12) + (m >> 14);
    // Angles outside [-pi/2, pi/2) are pre-rotated by pi so CORDIC only sees its convergent range
    assign fold = phase[15] != phase[14];

    always_comb begin
        x_d[0] = fold ? -mk : mk;
        y_d[0] = '0;
        z_d[0] = fold ? {~phase[15], phase[14:0]} : phase;
        for (int k = 0; k < NUM_ITER; k++) begin
            x_d[k+1] = z_q[k][15] ? x_q[k] + (y_q[k] >>> k) : x_q[k] - (y_q[k] >>> k);
            y_d[k+1] = z_q[k][15] ? y_q[k] - (x_q[k] >>> k) : y_q[k] + (x_q[k] >>> k);
        end
        for (int k = 0; k < NUM_ITER - 1; k++)
            z_d[k+1] = z_q[k][15] ? z_q[k] + ATAN[k] : z_q[k] - ATAN[k];
        stb_d = {stb_q[NUM_ITER:0], input_strobe};
        i_d   = out_sat(x_q[NUM_ITER]);
        q_d   = out_sat(y_q[NUM_ITER]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q   <= '{default: '0};
            y_q   <= '{default: '0};
            z_q   <= '{default: '0};
            stb_q <= '0;
            i_q   <= '0;
            q_q   <= '0;
        end else if (enable) begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            stb_q <= stb_d;
            i_q   <= i_d;
            q_q   <= q_d;
        end
    end

    assign i             = i_q;
    assign q             = q_q;
    assign output_strobe = stb_q[NUM_ITER+1];
endmodule

// File: tb/tb_polar_to_complex.sv
// tb_polar_to_complex: random and directed stimulus against a floating-point polar-to-rectangular delay-line model
module tb_polar_to_complex;
    localparam int LAT = 16;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic        [15:0] mag = '0;
    logic        [15:0] phase = '0;
    logic               input_strobe = 1'b0;
    logic signed [15:0] i, q;
    logic               output_strobe;

    typedef struct {
        bit stb;
        int mag;
        int ph;
    } smp_t;

    smp_t hist[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;

    polar_to_complex dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mag(mag),
        .phase(phase),
        .input_strobe(input_strobe),
        .i(i),
        .q(q),
        .output_strobe(output_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got - exp > tol || exp - got > tol) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d tol=%0d", tag, cyc, got, exp, tol);
        end
    endtask

    function automatic int ideal(input int m, input int ph, input bit is_q);
        real a, v;
        int  r;
        a = real'(ph) * 2.0 * 3.14159265358979 / 65536.0;
        v = real'(m) * (is_q ? $sin(a) : $cos(a));
        r = v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        return r > 32767 ? 32767 : (r < -32767 ? -32767 : r);
    endfunction

    task automatic step(input bit en, input bit rst, input bit stb, input int m, input int ph);
        int tol;
        enable       = en;
        reset        = rst;
        input_strobe = stb;
        mag          = 16'(m);
        phase        = 16'(ph);
        @(posedge clock);
        cyc++;
        if (rst) begin
            hist.delete();
            repeat (LAT) hist.push_back('{1'b0, 0, 0});
        end else if (en) begin
            hist.push_back('{stb, m, ph});
            void'(hist.pop_front());
        end
        #1;
        tol = hist[0].mag == 0 ? 0 : 4;
        check("strobe", int'(output_strobe), int'(hist[0].stb), 0);
        check("i", int'(i), ideal(hist[0].mag, hist[0].ph, 1'b0), tol);
        check("q", int'(q), ideal(hist[0].mag, hist[0].ph, 1'b1), tol);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 0, int'($urandom_range(0, 65535)) - 32768);
    endtask

    int dir_mag[12] = '{1000, 1000, 1000, 1000, 1000, 1000, 40000, 40000, 1000, 1000, 1000, 32767};
    int dir_ph[12]  = '{0, 16384, -32768, -16384, 8192, 24576, 0, 8192, 16383, -16385, 32767, -32768};

    initial begin
        repeat (LAT) hist.push_back('{1'b0, 0, 0});
        repeat (3) step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);
        for (int n = 0; n < 12; n++) begin
            step(1'b1, 1'b0, 1'b1, dir_mag[n], dir_ph[n]);
            idle(3);
        end
        idle(20);
        for (int n = 0; n < 64; n++) begin
            if (n == 32)
                repeat (3) step(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 32767)),
                                int'($urandom_range(0, 65535)) - 32768);
            step(1'b1, 1'b0, 1'b1, int'($urandom_range(0, 8191)),
                 int'($urandom_range(0, 65535)) - 32768);
        end
        idle(20);
        for (int n = 0; n < 5; n++)
            step(1'b1, 1'b0, 1'b1, int'($urandom_range(100, 8191)),
                 int'($urandom_range(0, 65535)) - 32768);
        step(1'b1, 1'b1, 1'b1, 3000, 4000);
        idle(20);
        step(1'b1, 1'b0, 1'b1, 2000, -12000);
        idle(20);
        for (int ph = -32767; ph <= 32767; ph += 2048)
            step(1'b1, 1'b0, 1'b1, 0, ph);
        step(1'b1, 1'b0, 1'b1, 0, 32767);
        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
